// File: rtl/ifu_pkg.sv
// Shared instruction-fetch constants: bubble encoding, reset address, fetch FSM states.
package ifu_pkg;

  localparam logic [31:0] INST_NOP       = 32'h0000_0013;
  localparam logic [31:0] IFU_RESET_ADDR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_WAIT = 2'd1,
    IFU_DROP = 2'd2
  } ifu_state_t;

endpackage

// File: rtl/ifu_if.sv
// Fetch unit bundle: redirect/stall inputs, instruction-memory port and IF/ID outputs.
interface ifu_if;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  modport master (
    input  jump_en_i, jump_addr_i, hold_i, imem_rvalid_i, imem_rdata_i,
    output imem_req_o, imem_addr_o, inst_o, inst_addr_o, inst_valid_o
  );

  modport slave (
    output jump_en_i, jump_addr_i, hold_i, imem_rvalid_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o, inst_o, inst_addr_o, inst_valid_o
  );
endinterface

// File: rtl/ifu_skid.sv
// One-entry instruction+address buffer that parks a response arriving during a stall.
module ifu_skid
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = IFU_RESET_ADDR,
  parameter logic [31:0] NOP_INST   = INST_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_inst,
  input  logic [31:0] load_addr,
  output logic        vld,
  output logic [31:0] inst,
  output logic [31:0] addr
);

  // clear wins so a redirect always empties the buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      vld  <= 1'b0;
      inst <= NOP_INST;
      addr <= RESET_ADDR;
    end else if (clear) begin
      vld <= 1'b0;
    end else if (load) begin
      vld  <= 1'b1;
      inst <= load_inst;
      addr <= load_addr;
    end
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch: PC, single-outstanding imem requests, IF/ID register with stall,
// redirect and bubble insertion. Stale responses after a redirect are dropped.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = IFU_RESET_ADDR,
  parameter logic [31:0] NOP_INST   = INST_NOP
) (
  input  logic clk,
  input  logic rst,
  ifu_if.master bus
);

  ifu_state_t  state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] req_addr_q;
  logic [31:0] inst_q;
  logic [31:0] inst_addr_q;
  logic        inst_vld_q;

  logic        rsp;
  logic        issue;
  logic        skid_vld;
  logic        skid_load;
  logic        skid_clear;
  logic [31:0] skid_inst;
  logic [31:0] skid_addr;

  // only a response to a live request counts; IDLE/DROP responses are ignored
  assign rsp = (state_q == IFU_WAIT) && bus.imem_rvalid_i;

  assign issue = !rst && !bus.hold_i && !bus.jump_en_i && !skid_vld &&
                 ((state_q == IFU_IDLE) || rsp);

  assign skid_load  = !bus.jump_en_i && bus.hold_i && rsp;
  assign skid_clear = bus.jump_en_i || (!bus.hold_i && !rsp && skid_vld);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IFU_IDLE: begin
        if (issue) state_d = IFU_WAIT;
      end
      IFU_WAIT: begin
        if (bus.jump_en_i)
          state_d = bus.imem_rvalid_i ? IFU_IDLE : IFU_DROP;
        else if (bus.imem_rvalid_i)
          state_d = issue ? IFU_WAIT : IFU_IDLE;
      end
      IFU_DROP: begin
        if (bus.imem_rvalid_i) state_d = IFU_IDLE;
      end
      default: state_d = IFU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IFU_IDLE;
      pc_q        <= RESET_ADDR;
      req_addr_q  <= RESET_ADDR;
      inst_q      <= NOP_INST;
      inst_addr_q <= RESET_ADDR;
      inst_vld_q  <= 1'b0;
    end else begin
      state_q <= state_d;

      if (bus.jump_en_i) begin
        pc_q <= bus.jump_addr_i & ~32'h3;
      end else if (issue) begin
        pc_q       <= pc_q + 32'd4;
        req_addr_q <= pc_q;
      end

      // redirect beats stall; a stall freezes the whole IF/ID register
      if (bus.jump_en_i) begin
        inst_q     <= NOP_INST;
        inst_vld_q <= 1'b0;
      end else if (!bus.hold_i) begin
        if (rsp) begin
          inst_q      <= bus.imem_rdata_i;
          inst_addr_q <= req_addr_q;
          inst_vld_q  <= 1'b1;
        end else if (skid_vld) begin
          inst_q      <= skid_inst;
          inst_addr_q <= skid_addr;
          inst_vld_q  <= 1'b1;
        end else begin
          inst_q     <= NOP_INST;
          inst_vld_q <= 1'b0;
        end
      end
    end
  end

  ifu_skid #(
    .RESET_ADDR (RESET_ADDR),
    .NOP_INST   (NOP_INST)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .clear     (skid_clear),
    .load_inst (bus.imem_rdata_i),
    .load_addr (req_addr_q),
    .vld       (skid_vld),
    .inst      (skid_inst),
    .addr      (skid_addr)
  );

  assign bus.imem_req_o   = issue;
  assign bus.imem_addr_o  = pc_q;
  assign bus.inst_o       = inst_q;
  assign bus.inst_addr_o  = inst_addr_q;
  assign bus.inst_valid_o = inst_vld_q;

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed cycle-exact scenarios plus a randomized run against a queue-based fetch model.
module tb_ifu;
  import ifu_pkg::*;

  localparam logic [31:0] RST_A = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  ifu_if bus ();

  ifu #(.RESET_ADDR(RST_A), .NOP_INST(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a == 32'h8) ? 32'hDEAD_BEEF : (a ^ 32'h1357_9BDF);
  endfunction

  // memory: fixed or random latency (cycles from request to rvalid), never reset
  int          lat_cfg  = 1;
  bit          rand_lat = 1'b0;
  logic        m_r;
  logic [31:0] m_a;
  logic [31:0] m_pa;
  int          m_cnt = 0;

  initial begin
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0;
    forever begin
      @(posedge clk);
      m_r = bus.imem_req_o;
      m_a = bus.imem_addr_o;
      #1;
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = $urandom;
      if (m_r === 1'b1) begin
        m_pa  = m_a;
        m_cnt = rand_lat ? int'($urandom_range(1, 4)) : lat_cfg;
      end
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          bus.imem_rvalid_i = 1'b1;
          bus.imem_rdata_i  = data_of(m_pa);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic h, input logic j, input logic [31:0] ja);
    bus.hold_i      = h;
    bus.jump_en_i   = j;
    bus.jump_addr_i = ja;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(1'b0, 1'b0, 32'h0);
    repeat (6) tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_valid(input string name, input logic [31:0] ea);
    int n;
    n = 0;
    while (bus.inst_valid_o !== 1'b1 && n < 12) begin
      tick();
      set_in(1'b0, 1'b0, 32'h0);
      n++;
    end
    n_checks++;
    if (bus.inst_valid_o !== 1'b1 || bus.inst_addr_o !== ea || bus.inst_o !== data_of(ea))
      $display("FAIL %s got v=%0b addr=%h inst=%h exp addr=%h inst=%h", name,
               bus.inst_valid_o, bus.inst_addr_o, bus.inst_o, ea, data_of(ea));
    else n_pass++;
  endtask

  task automatic test_reset();
    rand_lat = 1'b0; lat_cfg = 1;
    rst = 1'b1;
    set_in(1'b0, 1'b0, 32'h0);
    repeat (6) tick();
    #1;
    n_checks++;
    if (bus.imem_req_o !== 1'b0 || bus.imem_addr_o !== RST_A || bus.inst_o !== NOP ||
        bus.inst_addr_o !== RST_A || bus.inst_valid_o !== 1'b0)
      $display("FAIL reset_vals got req=%0b a=%h inst=%h ia=%h v=%0b exp req=0 a=%h inst=%h ia=%h v=0",
               bus.imem_req_o, bus.imem_addr_o, bus.inst_o, bus.inst_addr_o, bus.inst_valid_o, RST_A, NOP, RST_A);
    else n_pass++;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_stream();
    logic [31:0] ea;
    for (int c = 0; c < 5; c++) begin
      if (c != 0) begin tick(); set_in(1'b0, 1'b0, 32'h0); end
      if (c < 3) begin
        ea = 32'(c * 4);
        n_checks++;
        if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== ea)
          $display("FAIL stream_req%0d got req=%0b a=%h exp req=1 a=%h", c, bus.imem_req_o, bus.imem_addr_o, ea);
        else n_pass++;
      end
      if (c >= 2) begin
        ea = 32'((c - 2) * 4);
        n_checks++;
        if (bus.inst_valid_o !== 1'b1 || bus.inst_addr_o !== ea || bus.inst_o !== data_of(ea))
          $display("FAIL stream_out%0d got v=%0b ia=%h inst=%h exp v=1 ia=%h inst=%h", c,
                   bus.inst_valid_o, bus.inst_addr_o, bus.inst_o, ea, data_of(ea));
        else n_pass++;
      end else begin
        n_checks++;
        if (bus.inst_valid_o !== 1'b0)
          $display("FAIL stream_early%0d got v=%0b exp v=0", c, bus.inst_valid_o);
        else n_pass++;
      end
    end
  endtask

  task automatic test_hold();
    rand_lat = 1'b0; lat_cfg = 1;
    do_reset();
    tick(); set_in(1'b0, 1'b0, 32'h0);
    tick(); set_in(1'b0, 1'b0, 32'h0);
    for (int c = 3; c <= 6; c++) begin
      tick();
      set_in(c <= 5, 1'b0, 32'h0);
      n_checks++;
      if (bus.imem_req_o !== 1'b0 || bus.inst_valid_o !== 1'b1 || bus.inst_addr_o !== 32'h4 ||
          bus.inst_o !== data_of(32'h4))
        $display("FAIL hold_frozen%0d got req=%0b v=%0b ia=%h inst=%h exp req=0 v=1 ia=4 inst=%h", c,
                 bus.imem_req_o, bus.inst_valid_o, bus.inst_addr_o, bus.inst_o, data_of(32'h4));
      else n_pass++;
    end
    tick(); set_in(1'b0, 1'b0, 32'h0);
    n_checks++;
    if (bus.inst_valid_o !== 1'b1 || bus.inst_addr_o !== 32'h8 || bus.inst_o !== 32'hDEAD_BEEF ||
        bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'hC)
      $display("FAIL hold_release got v=%0b ia=%h inst=%h req=%0b a=%h exp v=1 ia=8 inst=deadbeef req=1 a=c",
               bus.inst_valid_o, bus.inst_addr_o, bus.inst_o, bus.imem_req_o, bus.imem_addr_o);
    else n_pass++;
  endtask

  task automatic test_jump_wait();
    rand_lat = 1'b0; lat_cfg = 3;
    do_reset();
    repeat (3) begin tick(); set_in(1'b0, 1'b0, 32'h0); end
    n_checks++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h4)
      $display("FAIL jw_b2b got req=%0b a=%h exp req=1 a=4", bus.imem_req_o, bus.imem_addr_o);
    else n_pass++;
    tick(); set_in(1'b0, 1'b1, 32'h100);
    n_checks++;
    if (bus.imem_req_o !== 1'b0 || bus.inst_valid_o !== 1'b1 || bus.inst_addr_o !== 32'h0)
      $display("FAIL jw_jumpcyc got req=%0b v=%0b ia=%h exp req=0 v=1 ia=0", bus.imem_req_o, bus.inst_valid_o, bus.inst_addr_o);
    else n_pass++;
    for (int c = 5; c <= 6; c++) begin
      tick(); set_in(1'b0, 1'b0, 32'h0);
      n_checks++;
      if (bus.inst_o !== NOP || bus.inst_valid_o !== 1'b0 || bus.imem_req_o !== 1'b0)
        $display("FAIL jw_nop%0d got inst=%h v=%0b req=%0b exp inst=%h v=0 req=0", c,
                 bus.inst_o, bus.inst_valid_o, bus.imem_req_o, NOP);
      else n_pass++;
    end
    tick(); set_in(1'b0, 1'b0, 32'h0);
    n_checks++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h100 || bus.inst_valid_o !== 1'b0)
      $display("FAIL jw_newreq got req=%0b a=%h v=%0b exp req=1 a=100 v=0", bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o);
    else n_pass++;
    wait_valid("jw_deliver", 32'h100);
  endtask

  task automatic test_jump_hold_buf();
    rand_lat = 1'b0; lat_cfg = 1;
    do_reset();
    tick(); set_in(1'b0, 1'b0, 32'h0);
    tick(); set_in(1'b1, 1'b0, 32'h0);
    tick(); set_in(1'b1, 1'b1, 32'h100);
    n_checks++;
    if (bus.imem_req_o !== 1'b0 || bus.inst_valid_o !== 1'b1 || bus.inst_addr_o !== 32'h0)
      $display("FAIL jhb_held got req=%0b v=%0b ia=%h exp req=0 v=1 ia=0", bus.imem_req_o, bus.inst_valid_o, bus.inst_addr_o);
    else n_pass++;
    tick(); set_in(1'b0, 1'b0, 32'h0);
    n_checks++;
    if (bus.inst_o !== NOP || bus.inst_valid_o !== 1'b0 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h100)
      $display("FAIL jhb_after got inst=%h v=%0b req=%0b a=%h exp inst=%h v=0 req=1 a=100",
               bus.inst_o, bus.inst_valid_o, bus.imem_req_o, bus.imem_addr_o, NOP);
    else n_pass++;
    wait_valid("jhb_deliver", 32'h100);
  endtask

  task automatic test_jump_align_wrap();
    logic [31:0] ea;
    rand_lat = 1'b0; lat_cfg = 1;
    do_reset();
    set_in(1'b0, 1'b1, 32'h500);
    tick(); set_in(1'b0, 1'b1, 32'h203);
    tick(); set_in(1'b0, 1'b0, 32'h0);
    n_checks++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h200)
      $display("FAIL align_req got req=%0b a=%h exp req=1 a=200", bus.imem_req_o, bus.imem_addr_o);
    else n_pass++;
    tick(); set_in(1'b0, 1'b1, 32'hFFFF_FFF9);
    for (int c = 0; c < 3; c++) begin
      tick(); set_in(1'b0, 1'b0, 32'h0);
      ea = 32'hFFFF_FFF8 + 32'(c * 4);
      n_checks++;
      if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== ea)
        $display("FAIL wrap_req%0d got req=%0b a=%h exp req=1 a=%h", c, bus.imem_req_o, bus.imem_addr_o, ea);
      else n_pass++;
    end
  endtask

  task automatic test_reset_in_wait();
    rand_lat = 1'b0; lat_cfg = 3;
    do_reset();
    tick(); rst = 1'b1; set_in(1'b0, 1'b0, 32'h0);
    tick();
    tick(); rst = 1'b0; set_in(1'b0, 1'b0, 32'h0);
    n_checks++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== RST_A || bus.inst_valid_o !== 1'b0)
      $display("FAIL rw_first_req got req=%0b a=%h v=%0b exp req=1 a=%h v=0", bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o, RST_A);
    else n_pass++;
    tick(); set_in(1'b0, 1'b0, 32'h0);
    n_checks++;
    if (bus.inst_o !== NOP || bus.inst_valid_o !== 1'b0 || bus.inst_addr_o !== RST_A)
      $display("FAIL rw_ignored got inst=%h v=%0b ia=%h exp inst=%h v=0 ia=%h", bus.inst_o, bus.inst_valid_o, bus.inst_addr_o, NOP, RST_A);
    else n_pass++;
    wait_valid("rw_deliver", RST_A);
  endtask

  task automatic test_random();
    logic [31:0] q_addr[$];
    logic [31:0] exp_pc, m_inst, m_addr, ja;
    logic        m_vld, addr_known, ph, pj, h, j;
    int          deliveries;
    rand_lat = 1'b1;
    do_reset();
    exp_pc = RST_A; m_inst = NOP; m_addr = RST_A; m_vld = 1'b0; addr_known = 1'b1;
    ph = 1'b1; pj = 1'b0; deliveries = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc != 0) tick();
      if (pj) begin
        m_inst = NOP; m_vld = 1'b0; addr_known = 1'b0;
      end else if (!ph) begin
        if (bus.inst_valid_o === 1'b1 && q_addr.size() > 0) begin
          m_addr = q_addr.pop_front();
          m_inst = data_of(m_addr); m_vld = 1'b1; addr_known = 1'b1;
          deliveries++;
        end else begin
          m_inst = NOP; m_vld = 1'b0;
        end
      end
      n_checks++;
      if (bus.inst_o !== m_inst || bus.inst_valid_o !== m_vld || (addr_known && bus.inst_addr_o !== m_addr))
        $display("FAIL rnd_out cyc=%0d got inst=%h v=%0b ia=%h exp inst=%h v=%0b ia=%h", cyc,
                 bus.inst_o, bus.inst_valid_o, bus.inst_addr_o, m_inst, m_vld, m_addr);
      else n_pass++;
      h  = ($urandom_range(0, 99) < 25);
      j  = ($urandom_range(0, 99) < 5);
      ja = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom_range(0, 1023));
      set_in(h, j, ja);
      if (bus.imem_req_o === 1'b1) begin
        n_checks++;
        if (h || j || bus.imem_addr_o !== exp_pc)
          $display("FAIL rnd_req cyc=%0d got a=%h hold=%0b jump=%0b exp a=%h no hold/jump", cyc, bus.imem_addr_o, h, j, exp_pc);
        else n_pass++;
        q_addr.push_back(exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
      if (j) begin
        exp_pc = {ja[31:2], 2'b00};
        q_addr.delete();
      end
      ph = h; pj = j;
    end
    n_checks++;
    if (deliveries < 50)
      $display("FAIL rnd_progress got deliveries=%0d exp >=50", deliveries);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    bus.hold_i = 1'b0; bus.jump_en_i = 1'b0; bus.jump_addr_i = 32'h0;
    test_reset();
    test_stream();
    test_hold();
    test_jump_wait();
    test_jump_hold_buf();
    test_jump_align_wrap();
    test_reset_in_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
